// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, NB_DATA data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits, paced by an oversampling tick.
module uart_tx_cfg #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0,
    parameter int NB_STOP = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done
);

    localparam int             SW          = $clog2(SB_TICK);
    localparam logic [SW-1:0]  S_LAST      = SW'(SB_TICK - 32'sd1);
    localparam logic [3:0]     N_DATA_LAST = 4'(NB_DATA - 32'sd1);
    localparam logic [3:0]     N_STOP_LAST = 4'(NB_STOP - 32'sd1);
    // PARITY==3 (illegal) deliberately falls through to "no parity bit"
    localparam logic           HAS_PAR     = (PARITY == 32'sd1) || (PARITY == 32'sd2);
    localparam logic           PAR_ODD     = (PARITY == 32'sd2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic calc_parity(input logic [NB_DATA-1:0] data);
        return PAR_ODD ? ~(^data) : (^data);
    endfunction

    state_t              state_r;
    logic [SW-1:0]       s_r;
    logic [3:0]          n_r;
    logic [NB_DATA-1:0]  shreg_r;
    logic                par_r;
    logic                tx_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic                bit_end_s;

    assign bit_end_s = i_tick && (s_r == S_LAST);

    // Frame sequencer: tick counter, bit counter, shift register and registered line outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            s_r     <= {SW{1'b0}};
            n_r     <= 4'd0;
            shreg_r <= {NB_DATA{1'b0}};
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state_r != ST_IDLE && i_tick) begin
                s_r <= bit_end_s ? {SW{1'b0}} : s_r + 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        shreg_r <= i_data;
                        par_r   <= calc_parity(i_data);
                        s_r     <= {SW{1'b0}};
                        n_r     <= 4'd0;
                        tx_r    <= 1'b0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        n_r     <= 4'd0;
                        tx_r    <= shreg_r[0];
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (n_r == N_DATA_LAST) begin
                            n_r <= 4'd0;
                            if (HAS_PAR) begin
                                tx_r    <= par_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            n_r     <= n_r + 4'd1;
                            shreg_r <= shreg_r >> 1;
                            tx_r    <= shreg_r[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        n_r     <= 4'd0;
                        tx_r    <= 1'b1;
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        if (n_r == N_STOP_LAST) begin
                            done_r  <= 1'b1;
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            n_r <= n_r + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx      = tx_r;
    assign o_ready   = ready_r;
    assign o_busy    = busy_r;
    assign o_tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: five parameter variants, a tick-level
// frame model compared every cycle, plus hand-computed frame expectations.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [8:0] data;
    logic       tick;
    int         sel;
    int         tick_div;
    logic       chk_en;
    int         checks = 0;
    int         errors = 0;

    logic [4:0] valid_v, tx_w, ready_w, busy_w, done_w;

    always #5 clk = ~clk;

    assign valid_v = valid ? (5'b00001 << sel) : 5'b00000;

    // Baud source: every cycle, or one strobe per tick_div cycles
    int   div_cnt = 0;
    logic div_hit = 1'b0;
    always @(posedge clk) begin
        div_cnt <= (div_cnt >= tick_div - 1) ? 0 : div_cnt + 1;
        div_hit <= (div_cnt >= tick_div - 1);
    end
    assign tick = (tick_div <= 1) ? 1'b1 : div_hit;

    uart_tx_cfg #(.NB_DATA(8), .SB_TICK(16), .PARITY(0), .NB_STOP(1)) u0 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data[7:0]), .i_valid(valid_v[0]),
        .o_ready(ready_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_tx_done(done_w[0]));
    uart_tx_cfg #(.NB_DATA(8), .SB_TICK(16), .PARITY(1), .NB_STOP(1)) u1 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data[7:0]), .i_valid(valid_v[1]),
        .o_ready(ready_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_tx_done(done_w[1]));
    uart_tx_cfg #(.NB_DATA(8), .SB_TICK(16), .PARITY(2), .NB_STOP(1)) u2 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data[7:0]), .i_valid(valid_v[2]),
        .o_ready(ready_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_tx_done(done_w[2]));
    uart_tx_cfg #(.NB_DATA(7), .SB_TICK(16), .PARITY(0), .NB_STOP(2)) u3 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data[6:0]), .i_valid(valid_v[3]),
        .o_ready(ready_w[3]), .o_tx(tx_w[3]), .o_busy(busy_w[3]), .o_tx_done(done_w[3]));
    uart_tx_cfg #(.NB_DATA(8), .SB_TICK(16), .PARITY(3), .NB_STOP(1)) u4 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_data(data[7:0]), .i_valid(valid_v[4]),
        .o_ready(ready_w[4]), .o_tx(tx_w[4]), .o_busy(busy_w[4]), .o_tx_done(done_w[4]));

    function automatic int p_nbd(input int k);
        return (k == 3) ? 7 : 8;
    endfunction
    function automatic int p_par(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : (k == 4) ? 3 : 0;
    endfunction
    function automatic int p_nst(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    // Whole frame as a bit list: index 0 = start bit, ones fill the stop bits
    function automatic logic [15:0] frame_of(input logic [8:0] d, input int k);
        logic [15:0] f;
        logic        p;
        int          nb;
        nb   = p_nbd(k);
        f    = 16'hFFFF;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f[1+i] = d[i];
            p      = p ^ d[i];
        end
        if (p_par(k) == 1) f[1+nb] = p;
        else if (p_par(k) == 2) f[1+nb] = ~p;
        return f;
    endfunction

    function automatic int flen(input int k);
        return 1 + p_nbd(k) + (((p_par(k) == 1) || (p_par(k) == 2)) ? 1 : 0) + p_nst(k);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: line value = frame bit (ticks since accept / 16)
    logic [15:0] m_frame;
    int          m_total;
    int          m_cnt;
    logic        m_busy, m_done, m_tx;
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_tx <= 1'b1; m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (valid) begin
                    m_frame <= frame_of(data, sel);
                    m_total <= flen(sel) * 16;
                    m_cnt   <= 0;
                    m_busy  <= 1'b1;
                    m_tx    <= 1'b0;
                end
            end else if (tick) begin
                if (m_cnt + 1 == m_total) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_tx <= 1'b1;
                end else begin
                    m_tx <= m_frame[(m_cnt + 1) / 16];
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_tx",    int'(tx_w[sel]),    int'(m_tx));
            chk("cyc_ready", int'(ready_w[sel]), int'(!m_busy));
            chk("cyc_busy",  int'(busy_w[sel]),  int'(m_busy));
            chk("cyc_done",  int'(done_w[sel]),  int'(m_done));
        end
    end

    // Send one word (tick every cycle), sample mid-bit, return cycles to done
    task automatic send_sample(input int k, input logic [8:0] d,
                               output logic [15:0] smp, output int dlen);
        sel   = k;
        smp   = 16'h0000;
        dlen  = -1;
        data  = d;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        for (int j = 0; j < 2000; j++) begin
            if ((j % 16) == 8 && (j / 16) < 16) smp[j/16] = tx_w[k];
            if (done_w[k]) begin
                dlen = j;
                chk("ready_at_done", int'(ready_w[k]), 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("done_single", int'(done_w[k]), 0);
    endtask

    task automatic wait_done(input string name);
        int found;
        found = 0;
        for (int j = 0; j < 2000; j++) begin
            if (done_w[sel]) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(name, found, 1);
    endtask

    logic [15:0] smp;
    int          dlen;
    int          seen;

    initial begin
        rst = 1'b1; valid = 1'b0; data = 9'h000; sel = 0; tick_div = 1; chk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_tx",    int'(tx_w[0]),    1);
        chk("rst_ready", int'(ready_w[0]), 1);
        chk("rst_busy",  int'(busy_w[0]),  0);
        chk("rst_done",  int'(done_w[0]),  0);
        rst = 1'b0;
        @(posedge clk); #1;

        send_sample(0, 9'h0AA, smp, dlen);
        chk("aa_bits", int'(smp[9:0]), 'h354);
        chk("aa_len",  dlen, 160);

        send_sample(1, 9'h007, smp, dlen);
        chk("even_data", int'(smp[8:1]), 'h07);
        chk("even_par",  int'(smp[9]), 1);
        chk("even_len",  dlen, 176);

        send_sample(2, 9'h007, smp, dlen);
        chk("odd_par", int'(smp[9]), 0);
        chk("odd_len", dlen, 176);

        send_sample(3, 9'h041, smp, dlen);
        chk("d7_data", int'(smp[7:1]), 'h41);
        chk("d7_stop", int'(smp[9:8]), 3);
        chk("d7_len",  dlen, 160);

        send_sample(4, 9'h0C3, smp, dlen);
        chk("par3_stop", int'(smp[9]), 1);
        chk("par3_len",  dlen, 160);

        // back-to-back with i_valid held high
        sel = 0; data = 9'h055; valid = 1'b1;
        @(posedge clk); #1;
        wait_done("b2b_done1");
        data = 9'h00F;
        chk("b2b_gap_tx", int'(tx_w[0]), 1);
        @(posedge clk); #1;
        chk("b2b_start2", int'(tx_w[0]), 0);
        chk("b2b_ready2", int'(ready_w[0]), 0);
        valid = 1'b0;
        wait_done("b2b_done2");
        @(posedge clk); #1;

        // request while busy must be ignored, data change must not corrupt frame
        data = 9'h055; valid = 1'b1;
        @(posedge clk); #1;
        data = 9'h0FF;
        repeat (30) begin @(posedge clk); #1; end
        chk("busy_ready", int'(ready_w[0]), 0);
        valid = 1'b0;
        wait_done("busy_done");
        @(posedge clk); #1;

        // reset mid-frame, colliding with a new request
        data = 9'h099; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (50) begin @(posedge clk); #1; end
        rst = 1'b1; valid = 1'b1; data = 9'h012;
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b0;
        chk("mid_rst_tx",    int'(tx_w[0]),    1);
        chk("mid_rst_ready", int'(ready_w[0]), 1);
        chk("mid_rst_busy",  int'(busy_w[0]),  0);
        seen = 0;
        repeat (200) begin
            if (done_w[0]) seen = 1;
            @(posedge clk); #1;
        end
        chk("mid_rst_nodone", seen, 0);
        send_sample(0, 9'h03C, smp, dlen);
        chk("post_rst_bits", int'(smp[9:0]), 'h278);
        chk("post_rst_len",  dlen, 160);

        // divided tick source: one strobe per 3 clocks
        tick_div = 3;
        repeat (4) begin @(posedge clk); #1; end
        send_sample(0, 9'h0A5, smp, dlen);
        chk("div_len", int'((dlen >= 478) && (dlen <= 480)), 1);
        tick_div = 1;
        repeat (4) begin @(posedge clk); #1; end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
